// File: rtl/mem_writer_if.sv
// Bundle of the batch-request and memory-write signals of mem_writer.
// The slave modport is the writer's view; master is the requester/memory side.
interface mem_writer_if #(
    parameter int DATA_W = 8,
    parameter int N_PE   = 4,
    parameter int N_OUT  = 16
);
    logic                            start;
    logic [7:0]                      x;
    logic [7:0]                      y;
    logic [7:0]                      z;
    logic [N_PE*N_OUT*DATA_W-1:0]    pe_data;
    logic                            mem_ready;
    logic                            wr_en;
    logic [7:0]                      wr_addr;
    logic [DATA_W-1:0]               wr_data;
    logic                            busy;
    logic                            done;

    modport master (
        output start, x, y, z, pe_data, mem_ready,
        input  wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  start, x, y, z, pe_data, mem_ready,
        output wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/mem_writer.sv
// Writes a latched batch of PE result words to memory, PE-major, with a
// ready/valid write handshake and a one-cycle done pulse at batch end.
module mem_writer #(
    parameter int DATA_W = 8,
    parameter int N_PE   = 4,
    parameter int N_OUT  = 16
) (
    input logic          clk,
    input logic          rst,
    mem_writer_if.slave  bus
);
    localparam int PW  = (N_PE  > 1) ? $clog2(N_PE)  : 1;
    localparam int KIW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int KW  = $clog2(N_OUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_FIN   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PW-1:0]     p_q, p_d;
    logic [KIW-1:0]    k_q, k_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [KW-1:0]     cnt_in;
    logic [7:0]        base_q, base_d;
    logic [7:0]        z_q, z_d;
    logic              load;
    logic              last_k;
    logic              last_p;
    logic              in_write;
    logic [DATA_W-1:0] words_q [N_PE][N_OUT];

    // Word count per channel, clamped to the number of words each PE holds.
    always_comb begin
        if (32'(bus.y) > 32'(N_OUT)) begin
            cnt_in = KW'(N_OUT);
        end else begin
            cnt_in = KW'(bus.y);
        end
    end

    assign last_k   = (KW'(k_q) == (cnt_q - KW'(1)));
    assign last_p   = (p_q == PW'(N_PE - 1));
    assign in_write = (state_q == ST_WRITE);

    // base_q tracks x + p*z incrementally so no multiplier is needed.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        z_d     = z_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    cnt_d   = cnt_in;
                    p_d     = '0;
                    k_d     = '0;
                    base_d  = bus.x;
                    z_d     = bus.z;
                    state_d = (cnt_in == '0) ? ST_FIN : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    if (last_k) begin
                        k_d = '0;
                        if (last_p) begin
                            state_d = ST_FIN;
                        end else begin
                            p_d    = p_q + PW'(1);
                            base_d = base_q + z_q;
                        end
                    end else begin
                        k_d = k_q + KIW'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            base_q  <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            z_q     <= z_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && load) begin
            for (int unsigned p = 0; p < N_PE; p++) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    words_q[p][k] <= bus.pe_data[(p*N_OUT + k)*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign bus.wr_en   = in_write;
    assign bus.wr_addr = in_write ? (base_q + 8'(k_q)) : '0;
    assign bus.wr_data = in_write ? words_q[p_q][k_q] : '0;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_FIN);

endmodule

// File: tb/tb_mem_writer.sv
// Randomized and directed bench for mem_writer against a queue-based model
// of the pending write sequence.
module tb_mem_writer;
    localparam int DW = 8;
    localparam int NP = 4;
    localparam int NO = 16;
    localparam int PDW = NP*NO*DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_writer_if #(.DATA_W(DW), .N_PE(NP), .N_OUT(NO)) bus ();

    mem_writer #(.DATA_W(DW), .N_PE(NP), .N_OUT(NO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_cnt   = 0;
    int done_cyc   = -1;
    int wen_cycles = 0;
    int busy_cycles = 0;

    logic [15:0] exp_q [$];   // pending {addr, data} writes still to be accepted
    bit          fin_pend;    // batch finished, done pulse still owed
    logic [15:0] acc_log [$]; // writes the DUT actually had accepted

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [PDW-1:0] pd, input int p, input int k);
        return pd[(p*NO + k)*DW +: DW];
    endfunction

    task automatic compare();
        bit         en;
        logic [7:0] a;
        logic [7:0] d;
        en = (exp_q.size() != 0);
        a  = en ? exp_q[0][15:8] : 8'h00;
        d  = en ? exp_q[0][7:0]  : 8'h00;
        chk("wr_en",   32'(bus.wr_en),   32'(en));
        chk("wr_addr", 32'(bus.wr_addr), 32'(a));
        chk("wr_data", 32'(bus.wr_data), 32'(d));
        chk("busy",    32'(bus.busy),    32'(en || fin_pend));
        chk("done",    32'(bus.done),    32'(!en && fin_pend));
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.wr_en) wen_cycles++;
        if (bus.busy) busy_cycles++;
    endtask

    // Apply the current inputs to the model and DUT for one clock edge.
    task automatic tick();
        int c;
        cyc++;
        if (!rst && bus.wr_en && bus.mem_ready) acc_log.push_back({bus.wr_addr, bus.wr_data});
        if (rst) begin
            exp_q.delete();
            fin_pend = 1'b0;
        end else if (exp_q.size() != 0) begin
            if (bus.mem_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) fin_pend = 1'b1;
            end
        end else if (fin_pend) begin
            fin_pend = 1'b0;
        end else if (bus.start) begin
            c = (int'(bus.y) > NO) ? NO : int'(bus.y);
            for (int p = 0; p < NP; p++)
                for (int k = 0; k < c; k++)
                    exp_q.push_back({8'(int'(bus.x) + p*int'(bus.z) + k), word_of(bus.pe_data, p, k)});
            if (c == 0) fin_pend = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    function automatic logic [PDW-1:0] pattern_pd();
        logic [PDW-1:0] pd;
        pd = '0;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < NO; k++)
                pd[(p*NO + k)*DW +: DW] = 8'(p*16 + k);
        return pd;
    endfunction

    function automatic logic [PDW-1:0] random_pd();
        logic [PDW-1:0] pd;
        for (int i = 0; i < PDW/32; i++) pd[i*32 +: 32] = $urandom;
        return pd;
    endfunction

    // Issue one batch, stall the first 'stall' presented cycles, wait for done.
    task automatic run(input logic [7:0] xv, input logic [7:0] yv, input logic [7:0] zv,
                       input logic [PDW-1:0] pd, input int stall, output int s);
        int n;
        int st;
        bus.start = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        bus.x = xv; bus.y = yv; bus.z = zv; bus.pe_data = pd;
        bus.start = 1'b1;
        tick();
        s = cyc;
        bus.start = 1'b0;
        n = 0;
        st = stall;
        while (done_cyc < s && n < 400) begin
            if (st > 0) begin
                bus.mem_ready = 1'b0;
                st--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            tick();
            n++;
        end
        if (done_cyc < s) begin
            errors++;
            $display("FAIL done_timeout actual=none required=done cycle=%0d", cyc);
        end
        bus.mem_ready = 1'b1;
    endtask

    logic [7:0] ref_a [8] = '{8'h10, 8'h11, 8'h30, 8'h31, 8'h50, 8'h51, 8'h70, 8'h71};
    logic [7:0] ref_d [8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};

    initial begin
        int s;
        int dc;
        logic [PDW-1:0] pd;

        rst = 1'b1;
        bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.z = '0;
        bus.pe_data = '0; bus.mem_ready = 1'b1;
        fin_pend = 1'b0;
        tick();
        tick();
        chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset_busy",  32'(bus.busy),  32'd0);
        chk("reset_done",  32'(bus.done),  32'd0);
        rst = 1'b0;

        // Basic batch with literal expected writes.
        acc_log.delete();
        run(8'h10, 8'd2, 8'h20, pattern_pd(), 0, s);
        chk("b1_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) begin
            chk("b1_addr", 32'(acc_log[i][15:8]), 32'(ref_a[i]));
            chk("b1_data", 32'(acc_log[i][7:0]),  32'(ref_d[i]));
        end
        chk("b1_done_lat", 32'(done_cyc - s + 1), 32'd9);

        // Same batch with a 3-cycle stall on the first write.
        acc_log.delete();
        wen_cycles = 0;
        run(8'h10, 8'd2, 8'h20, pattern_pd(), 3, s);
        chk("b2_count", 32'(acc_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++)
            chk("b2_seq", 32'(acc_log[i]), 32'({ref_a[i], ref_d[i]}));
        chk("b2_wen_cycles", 32'(wen_cycles), 32'd11);
        chk("b2_done_lat", 32'(done_cyc - s + 1), 32'd12);

        // Zero-length batch.
        acc_log.delete();
        run(8'h33, 8'd0, 8'h01, pattern_pd(), 0, s);
        busy_cycles = 1;  // the FIN cycle was just observed
        tick();
        tick();
        chk("b3_count", 32'(acc_log.size()), 32'd0);
        chk("b3_done_lat", 32'(done_cyc - s + 1), 32'd1);
        chk("b3_busy_cycles", 32'(busy_cycles), 32'd1);

        // Clamp to N_OUT and 8-bit address wrap.
        acc_log.delete();
        run(8'hF8, 8'd20, 8'h10, random_pd(), 0, s);
        chk("b4_count", 32'(acc_log.size()), 32'd64);
        if (acc_log.size() >= 17) begin
            chk("b4_first_addr", 32'(acc_log[0][15:8]),  32'hF8);
            chk("b4_ninth_addr", 32'(acc_log[8][15:8]),  32'h00);
            chk("b4_pe1_addr",   32'(acc_log[16][15:8]), 32'h08);
        end

        // Reset after three accepted writes aborts the batch.
        acc_log.delete();
        pd = random_pd();
        tick();
        bus.x = 8'h40; bus.y = 8'd4; bus.z = 8'h20; bus.pe_data = pd;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        chk("b5_accepted", 32'(acc_log.size()), 32'd3);
        dc = done_cnt;
        rst = 1'b1;
        tick();
        chk("b5_rst_wr_en", 32'(bus.wr_en), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("b5_no_done", 32'(done_cnt), 32'(dc));
        acc_log.delete();
        run(8'h40, 8'd4, 8'h20, pd, 0, s);
        if (acc_log.size() > 0)
            chk("b5_restart_first", 32'(acc_log[0]), 32'({8'h40, word_of(pd, 0, 0)}));

        // Start pulse and x change mid-batch are ignored.
        acc_log.delete();
        dc = done_cnt;
        tick();
        bus.x = 8'h10; bus.y = 8'd3; bus.z = 8'h08; bus.pe_data = pattern_pd();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        bus.start = 1'b1; bus.x = 8'hA0;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        chk("b6_done_once", 32'(done_cnt - dc), 32'd1);
        chk("b6_count", 32'(acc_log.size()), 32'd12);
        if (acc_log.size() >= 12)
            chk("b6_last_addr", 32'(acc_log[11][15:8]), 32'h10 + 32'h18 + 32'd2);

        // Randomized traffic including held start, stalls and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 249) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.x = 8'($urandom);
            bus.z = 8'($urandom);
            bus.y = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            bus.pe_data = random_pd();
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 Parameter DATA_W, default 8: width of one result word.
REQ-002 Parameter N_PE, default 4: number of processing-element result channels.
REQ-003 Parameter N_OUT, default 16: result words per PE channel.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to write one result batch; sampled only in IDLE.
REQ-007 x  input  8  base write address of the batch.
REQ-008 y  input  8  valid word count per PE channel.
REQ-009 z  input  8  address stride between PE channels.
REQ-010 pe_data  input  N_PE*N_OUT*DATA_W  flattened results; word (p,k) at bits [(p*N_OUT+k)*DATA_W +: DATA_W].
REQ-011 mem_ready  input  1  memory accepts the presented write this cycle.
REQ-012 wr_en  output  1  write request valid.
REQ-013 wr_addr  output  8  write address.
REQ-014 wr_data  output  DATA_W  write data.
REQ-015 busy  output  1  batch in progress.
REQ-016 done  output  1  one-cycle pulse after batch completion.

Function
REQ-017 The FSM SHALL have states IDLE, WRITE and FIN.
REQ-018 In IDLE with start=1, the block SHALL latch pe_data, x, z and cnt = min(y, N_OUT) into internal registers, clear p and k to 0, and go to WRITE; later input changes SHALL NOT affect the batch.
REQ-019 If latched cnt=0, IDLE SHALL go directly to FIN with no write issued.
REQ-020 In WRITE: wr_en=1, wr_addr = (x + p*z + k) mod 256, wr_data = latched word (p,k).
REQ-021 A write SHALL be accepted only in a cycle where wr_en=1 and mem_ready=1.
REQ-022 While mem_ready=0, wr_en, wr_addr and wr_data SHALL stay stable, and p and k SHALL NOT advance.
REQ-023 On acceptance, k SHALL increment; when k=cnt-1, k SHALL return to 0 and p SHALL increment, so writes are PE-major (p=0 for k=0..cnt-1, then p=1, and so on).
REQ-024 Acceptance with p=N_PE-1 and k=cnt-1 SHALL move the FSM to FIN.
REQ-025 In FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-026 busy SHALL be 1 in WRITE and FIN and 0 in IDLE.
REQ-027 start asserted while busy=1 SHALL be ignored and not queued.
REQ-028 start held high SHALL begin a new batch on the first IDLE cycle after done.
REQ-029 Address arithmetic SHALL be 8-bit and wrap modulo 256 with no error flag.
REQ-030 Latency: start in cycle t gives the first wr_en in cycle t+1.
REQ-031 With mem_ready tied high: N_PE*cnt consecutive writes, done in cycle t+1+N_PE*cnt.
REQ-032 Outside WRITE, wr_en=0 and wr_addr and wr_data SHALL be 0.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE; wr_en, busy and done = 0; wr_addr, wr_data, p, k and cnt = 0.
REQ-034 Reset SHALL take priority over start and mem_ready.
REQ-035 Reset mid-batch SHALL abort immediately: no further writes and no done pulse.

Verification
REQ-036 Defaults, x=0x10, y=2, z=0x20, mem_ready=1, word(p,k)=p*16+k: writes (0x10,0x00),(0x11,0x01),(0x30,0x10),(0x31,0x11),(0x50,0x20),(0x51,0x21),(0x70,0x30),(0x71,0x31); done in cycle t+9.
REQ-037 Same batch with mem_ready=0 for 3 cycles during the first write: (0x10,0x00) held 4 cycles; sequence unchanged; done delayed by 3 cycles.
REQ-038 y=0: no wr_en; done in cycle t+1; busy high for 1 cycle.
REQ-039 y=20, x=0xF8, z=0x10: cnt clamps to 16; 64 writes total; first address 0xF8, 9th address 0x00 (wrap).
REQ-040 rst asserted after 3 accepted writes: wr_en=0 next cycle, no done; a new start then writes from address x with k=0.
REQ-041 start pulsed during WRITE and x changed mid-batch: no effect on the current batch; exactly one done.
